// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: register-file source select and load size.
package wb_pkg;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'd0,
    MTR_MEM  = 2'd1,
    MTR_LINK = 2'd2,
    MTR_EXT  = 2'd3
  } memtoReg_e;

  // Encoding 3 is a second word encoding, so it shares the pass-through path.
  typedef enum logic [1:0] {
    LS_WORD  = 2'd0,
    LS_HALF  = 2'd1,
    LS_BYTE  = 2'd2,
    LS_WORD3 = 2'd3
  } loadSize_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational little-endian sub-word extract plus zero/sign extension for loads.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] ReadData,
  input  logic [1:0]        off,
  input  logic [1:0]        LoadSize,
  input  logic              LoadUnsigned,
  output logic [DATA_W-1:0] LoadData
);

  logic [7:0]  byteLane [4];
  logic [7:0]  selByte;
  logic [15:0] selHalf;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      assign byteLane[gi] = ReadData[gi*8 +: 8];
    end
  endgenerate

  assign selByte = byteLane[off];
  // Halfword lane comes from off[1] alone; a misaligned off[0] is ignored.
  assign selHalf = off[1] ? {byteLane[3], byteLane[2]} : {byteLane[1], byteLane[0]};

  always_comb begin
    LoadData = ReadData;
    case (loadSize_e'(LoadSize))
      LS_BYTE: LoadData = {{(DATA_W-8){~LoadUnsigned & selByte[7]}}, selByte};
      LS_HALF: LoadData = {{(DATA_W-16){~LoadUnsigned & selHalf[15]}}, selHalf};
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Write-back stage: MEM/WB register, load alignment, register-file source mux.
// Optional retired-instruction counter enabled by defining WB_PERF_CNT_EN.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  InValid,
  input  logic                  RegWrite_in,
  input  logic [REG_ADDR_W-1:0] WriteReg_in,
  input  logic [1:0]            MemtoReg_in,
  input  logic [1:0]            LoadSize_in,
  input  logic                  LoadUnsigned,
  input  logic [DATA_W-1:0]     ALUResult_in,
  input  logic [DATA_W-1:0]     ReadData_in,
  input  logic [DATA_W-1:0]     PCAddResult_in,
  input  logic [DATA_W-1:0]     ExtData_in,
  output logic                  RegWrite_out,
  output logic [REG_ADDR_W-1:0] WriteReg_out,
  output logic [DATA_W-1:0]     WriteData,
  output logic [CNT_W-1:0]      RetireCount
);

  logic                  validReg;
  logic                  regWriteReg;
  logic [REG_ADDR_W-1:0] writeRegReg;
  logic [1:0]            memtoRegReg;
  logic [1:0]            loadSizeReg;
  logic                  loadUnsignedReg;
  logic [DATA_W-1:0]     aluResultReg;
  logic [DATA_W-1:0]     readDataReg;
  logic [DATA_W-1:0]     pcAddReg;
  logic [DATA_W-1:0]     extDataReg;
  logic [DATA_W-1:0]     loadData;

  // Flush only kills the valid bit; the stale payload is harmless once invalid.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      validReg        <= 1'b0;
      regWriteReg     <= 1'b0;
      writeRegReg     <= '0;
      memtoRegReg     <= '0;
      loadSizeReg     <= '0;
      loadUnsignedReg <= 1'b0;
      aluResultReg    <= '0;
      readDataReg     <= '0;
      pcAddReg        <= '0;
      extDataReg      <= '0;
    end else if (Flush) begin
      validReg <= 1'b0;
    end else if (!Stall) begin
      validReg        <= InValid;
      regWriteReg     <= RegWrite_in;
      writeRegReg     <= WriteReg_in;
      memtoRegReg     <= MemtoReg_in;
      loadSizeReg     <= LoadSize_in;
      loadUnsignedReg <= LoadUnsigned;
      aluResultReg    <= ALUResult_in;
      readDataReg     <= ReadData_in;
      pcAddReg        <= PCAddResult_in;
      extDataReg      <= ExtData_in;
    end
  end

  wb_load_align #(
    .DATA_W(DATA_W)
  ) uLoadAlign (
    .ReadData    (readDataReg),
    .off         (aluResultReg[1:0]),
    .LoadSize    (loadSizeReg),
    .LoadUnsigned(loadUnsignedReg),
    .LoadData    (loadData)
  );

  always_comb begin
    WriteData = aluResultReg;
    case (memtoReg_e'(memtoRegReg))
      MTR_MEM:  WriteData = loadData;
      MTR_LINK: WriteData = pcAddReg;
      MTR_EXT:  WriteData = extDataReg;
      default:  ;
    endcase
  end

  assign RegWrite_out = validReg & regWriteReg & (writeRegReg != '0);
  assign WriteReg_out = writeRegReg;

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] retireCountReg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      retireCountReg <= '0;
    end else if (InValid && !Stall && !Flush) begin
      retireCountReg <= retireCountReg + 1'b1;
    end
  end

  assign RetireCount = retireCountReg;
`else
  assign RetireCount = '0;
`endif

endmodule
